mac_rx_frame_parser: RTL

Downstream stage of the MAC receive CRC checker, in the `logic_clk` domain. It consumes the byte stream the CRC checker's FIFO delivers: destination MAC, source MAC, EtherType, payload, then the 4-byte FCS. It filters frames on destination address, strips the 14-byte header and the trailing FCS, and presents the payload as a byte stream with header sideband to the upper protocol layers.

---
 rtl/mac_rx_frame_parser.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_rx_frame_parser.sv
// MAC receive frame parser: destination filtering, header/FCS stripping, payload stream with sideband.
// Optional MAC_RX_PROMISC_EN adds promisc_in to bypass the destination filter.
module mac_rx_frame_parser #(
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [47:0] local_mac_in,
`ifdef MAC_RX_PROMISC_EN
  input  logic        promisc_in,
`endif
  input  logic [7:0]  mac_rdata_in,
  input  logic        mac_rvalid_in,
  output logic        mac_rready_out,
  input  logic        mac_rlast_in,
  output logic [7:0]  eth_rdata_out,
  output logic        eth_rvalid_out,
  input  logic        eth_rready_in,
  output logic        eth_rlast_out,
  output logic        eth_ruser_out,
  output logic [15:0] eth_type_out,
  output logic [47:0] eth_src_mac_out,
  output logic        eth_hdr_valid_out,
  output logic [15:0] drop_cnt_out
);

  typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DROP} state_t;

  localparam logic [10:0] LAST_CNT = 11'(MAX_FRAME_LEN - 1);

  state_t      r_state, w_next_state;
  logic [10:0] r_byte_cnt;
  logic [2:0]  r_fill;
  logic [7:0]  r_buf [4];
  logic        r_match_local, r_match_bcast;
  logic [47:0] r_src_shift;
  logic [7:0]  r_type_hi;
  logic [7:0]  r_out_data;
  logic        r_out_valid, r_out_last, r_out_user;
  logic        r_hdr_valid;
  logic [47:0] r_src_mac;
  logic [15:0] r_type;
  logic [15:0] r_drop_cnt;

  logic        w_beat, w_buf_full, w_match;
  logic [7:0]  w_da_byte;
  logic        w_drop_inc, w_hdr_accept, w_push, w_push_last, w_push_user, w_flush;

  assign w_buf_full     = (r_fill == 3'd4);
  // Only a full delay buffer can push into the output register, so only then does backpressure matter.
  assign mac_rready_out = logic_rst_n &&
                          ((r_state != S_PAYLOAD) || !w_buf_full || !r_out_valid || eth_rready_in);
  assign w_beat         = mac_rvalid_in && mac_rready_out;

`ifdef MAC_RX_PROMISC_EN
  assign w_match = promisc_in || r_match_local || r_match_bcast;
`else
  assign w_match = r_match_local || r_match_bcast;
`endif

  always_comb begin
    case (r_byte_cnt[2:0])
      3'd0:    w_da_byte = local_mac_in[47:40];
      3'd1:    w_da_byte = local_mac_in[39:32];
      3'd2:    w_da_byte = local_mac_in[31:24];
      3'd3:    w_da_byte = local_mac_in[23:16];
      3'd4:    w_da_byte = local_mac_in[15:8];
      default: w_da_byte = local_mac_in[7:0];
    endcase
  end

  // NOTE: every signal driven here gets a default first, otherwise untouched paths infer latches.
  always_comb begin
    w_next_state = r_state;
    w_drop_inc   = 1'b0;
    w_hdr_accept = 1'b0;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_push_user  = 1'b0;
    w_flush      = 1'b0;
    if (w_beat) begin
      case (r_state)
        S_HEADER: begin
          if (mac_rlast_in) begin
            w_drop_inc = 1'b1;
          end else if (r_byte_cnt == 11'd13) begin
            if (w_match) begin
              w_hdr_accept = 1'b1;
              w_next_state = S_PAYLOAD;
            end else begin
              w_drop_inc   = 1'b1;
              w_next_state = S_DROP;
            end
          end
        end
        S_PAYLOAD: begin
          w_push = w_buf_full;
          if (mac_rlast_in) begin
            w_next_state = S_HEADER;
            w_flush      = 1'b1;
            w_push_last  = 1'b1;
            w_drop_inc   = !w_buf_full;
          end else if (r_byte_cnt == LAST_CNT) begin
            w_next_state = S_DROP;
            w_flush      = 1'b1;
            w_push_last  = 1'b1;
            w_push_user  = 1'b1;
          end
        end
        S_DROP: begin
          if (mac_rlast_in) w_next_state = S_HEADER;
        end
        default: w_next_state = S_HEADER;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) r_state <= S_HEADER;
    else              r_state <= w_next_state;
  end

  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      r_byte_cnt    <= '0;
      r_fill        <= '0;
      r_match_local <= 1'b0;
      r_match_bcast <= 1'b0;
      r_src_shift   <= '0;
      r_type_hi     <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_user    <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_src_mac     <= '0;
      r_type        <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_beat) begin
        if (mac_rlast_in)              r_byte_cnt <= '0;
        else if (r_byte_cnt != 11'h7FF) r_byte_cnt <= r_byte_cnt + 11'd1;
      end

      if (w_beat && r_state == S_HEADER) begin
        if (r_byte_cnt == 11'd0) begin
          r_match_local <= (mac_rdata_in == w_da_byte);
          r_match_bcast <= (mac_rdata_in == 8'hFF);
        end else if (r_byte_cnt < 11'd6) begin
          r_match_local <= r_match_local && (mac_rdata_in == w_da_byte);
          r_match_bcast <= r_match_bcast && (mac_rdata_in == 8'hFF);
        end else if (r_byte_cnt < 11'd12) begin
          r_src_shift <= {r_src_shift[39:0], mac_rdata_in};
        end else if (r_byte_cnt == 11'd12) begin
          r_type_hi <= mac_rdata_in;
        end
      end

      r_hdr_valid <= w_hdr_accept;
      if (w_hdr_accept) begin
        r_src_mac <= r_src_shift;
        r_type    <= {r_type_hi, mac_rdata_in};
      end

      if (w_flush)                                          r_fill <= '0;
      else if (w_beat && r_state == S_PAYLOAD && !w_buf_full) r_fill <= r_fill + 3'd1;

      if (w_push) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_buf[0];
        r_out_last  <= w_push_last;
        r_out_user  <= w_push_user;
      end else if (r_out_valid && eth_rready_in) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop_inc && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // NOTE: the delay buffer needs no reset; r_fill alone defines which entries are meaningful.
  always_ff @(posedge logic_clk) begin
    if (w_beat && r_state == S_PAYLOAD) begin
      if (w_buf_full) begin
        r_buf[0] <= r_buf[1];
        r_buf[1] <= r_buf[2];
        r_buf[2] <= r_buf[3];
        r_buf[3] <= mac_rdata_in;
      end else begin
        r_buf[r_fill[1:0]] <= mac_rdata_in;
      end
    end
  end

  assign eth_rdata_out     = r_out_data;
  assign eth_rvalid_out    = r_out_valid;
  assign eth_rlast_out     = r_out_last;
  assign eth_ruser_out     = r_out_user;
  assign eth_type_out      = r_type;
  assign eth_src_mac_out   = r_src_mac;
  assign eth_hdr_valid_out = r_hdr_valid;
  assign drop_cnt_out      = r_drop_cnt;

endmodule
